// File: rtl/tv80_busgen_pkg.sv
// Shared constants for the TV80 bus-strobe generator: cycle-class encodings,
// wait-counter width and the class decode used by the wait generator.
package tv80_busgen_pkg;

    localparam int WCNT_W = 3;

    typedef enum logic [2:0] {
        CLS_INTERNAL = 3'd0,
        CLS_FETCH    = 3'd1,
        CLS_INTA     = 3'd2,
        CLS_IO       = 3'd3,
        CLS_MEM      = 3'd4
    } cyc_class_e;

    function automatic cyc_class_e decode_class(
        input logic m1,
        input logic intcycle_n,
        input logic iorq,
        input logic write,
        input logic no_read
    );
        if (m1) begin
            return intcycle_n ? CLS_FETCH : CLS_INTA;
        end
        if (iorq) begin
            return CLS_IO;
        end
        if (write || !no_read) begin
            return CLS_MEM;
        end
        return CLS_INTERNAL;
    endfunction

endpackage

// File: rtl/tv80_busgen_waitgen.sv
// Cycle-class decode and automatic wait-state counter. The counter is loaded
// in T1 and counts down through T2, holding the core in T2 until it empties.
module tv80_waitgen
    import tv80_busgen_pkg::*;
#(
    parameter int MEM_WAIT = 0,
    parameter int IO_WAIT  = 1,
    parameter int M1_WAIT  = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       m1,
    input  logic       intcycle_n,
    input  logic       iorq,
    input  logic       write,
    input  logic       no_read,
    input  logic       ts_t1,
    input  logic       ts_t2,
    input  logic       ext_wait_n,
    output cyc_class_e cls,
    output logic       core_wait_n,
    output logic       wait_active
);

    localparam logic [WCNT_W-1:0] MEM_N = WCNT_W'(MEM_WAIT);
    localparam logic [WCNT_W-1:0] IO_N  = WCNT_W'(IO_WAIT);
    localparam logic [WCNT_W-1:0] M1_N  = WCNT_W'(M1_WAIT);

    logic [WCNT_W-1:0] wcnt_q;
    logic [WCNT_W-1:0] wcnt_d;
    logic [WCNT_W-1:0] n_sel;

    assign cls = decode_class(m1, intcycle_n, iorq, write, no_read);

    always_comb begin
        n_sel = '0;
        case (cls)
            CLS_FETCH: n_sel = M1_N;
            CLS_INTA:  n_sel = IO_N;
            CLS_IO:    n_sel = IO_N;
            CLS_MEM:   n_sel = MEM_N;
            default:   n_sel = '0;
        endcase
    end

    // A T1 load always wins, so an aborted cycle never leaves stale waits behind.
    always_comb begin
        wcnt_d = wcnt_q;
        if (ts_t1) begin
            wcnt_d = n_sel;
        end else if (ts_t2 && (wcnt_q != '0)) begin
            wcnt_d = wcnt_q - WCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign core_wait_n = ext_wait_n & ((wcnt_q == '0) | ~ts_t2);
    assign wait_active = (wcnt_q != '0);

endmodule

// File: rtl/tv80_busgen.sv
// Z80 bus-strobe generator: decodes core M/T state into negedge-registered
// MREQ/IORQ/RD/WR, adds automatic wait states and latches read data.
module tv80_busgen
    import tv80_busgen_pkg::*;
#(
    parameter int DW        = 8,
    parameter int T2WRITE   = 0,
    parameter int MEM_WAIT  = 0,
    parameter int IO_WAIT   = 1,
    parameter int M1_WAIT   = 0,
    parameter int RFSH_MREQ = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [6:0]    mc,
    input  logic [6:0]    ts,
    input  logic          intcycle_n,
    input  logic          no_read,
    input  logic          write,
    input  logic          iorq,
    input  logic          ext_wait_n,
    output logic          core_wait_n,
    input  logic [DW-1:0] di,
    output logic [DW-1:0] di_reg,
    output logic          mreq_n,
    output logic          iorq_n,
    output logic          rd_n,
    output logic          wr_n,
    output logic          wait_active
);

    cyc_class_e    cls;
    logic          mreq_n_q, iorq_n_q, rd_n_q, wr_n_q;
    logic          mreq_n_d, iorq_n_d, rd_n_d, wr_n_d;
    logic [DW-1:0] di_reg_q, di_reg_d;
    logic          wr_window;
    logic          unused_state_bits;

    assign unused_state_bits = ^{mc[6:1], ts[6:4]};

    tv80_waitgen #(
        .MEM_WAIT (MEM_WAIT),
        .IO_WAIT  (IO_WAIT),
        .M1_WAIT  (M1_WAIT)
    ) u_waitgen (
        .clk         (clk),
        .reset_n     (reset_n),
        .m1          (mc[0]),
        .intcycle_n  (intcycle_n),
        .iorq        (iorq),
        .write       (write),
        .no_read     (no_read),
        .ts_t1       (ts[0]),
        .ts_t2       (ts[1]),
        .ext_wait_n  (ext_wait_n),
        .cls         (cls),
        .core_wait_n (core_wait_n),
        .wait_active (wait_active)
    );

    // Early write asserts through T2 and stays low in T3 only while stalled.
    assign wr_window = (T2WRITE != 0) ? (ts[1] | (ts[2] & ~core_wait_n)) : ts[2];

    always_comb begin
        mreq_n_d = 1'b1;
        iorq_n_d = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        if ((cls == CLS_FETCH) || (cls == CLS_INTA)) begin
            if (ts[1] | ts[2]) begin
                rd_n_d   = ~intcycle_n;
                mreq_n_d = ~intcycle_n;
                iorq_n_d = intcycle_n;
            end else if (ts[3] && (cls == CLS_FETCH) && (RFSH_MREQ != 0)) begin
                mreq_n_d = 1'b0;
            end
        end else begin
            if ((ts[1] | ts[2]) && !no_read && !write) begin
                rd_n_d   = 1'b0;
                iorq_n_d = ~iorq;
                mreq_n_d = iorq;
            end
            if (write && wr_window) begin
                wr_n_d   = 1'b0;
                iorq_n_d = ~iorq;
                mreq_n_d = iorq;
            end
        end
    end

    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mreq_n_q <= 1'b1;
            iorq_n_q <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
        end else begin
            mreq_n_q <= mreq_n_d;
            iorq_n_q <= iorq_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
        end
    end

    assign di_reg_d = (ts[2] & core_wait_n) ? di : di_reg_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            di_reg_q <= '0;
        end else begin
            di_reg_q <= di_reg_d;
        end
    end

    assign mreq_n = mreq_n_q;
    assign iorq_n = iorq_n_q;
    assign rd_n   = rd_n_q;
    assign wr_n   = wr_n_q;
    assign di_reg = di_reg_q;

endmodule

// File: tb/tb_tv80_busgen.sv
// Directed bench for tv80_busgen: a small core emulator walks M/T states and
// two parameterisations are checked against hand-computed strobe counts.
module tb_tv80_busgen;

    typedef struct {
        int rd_lo;
        int wr_lo;
        int mreq_lo;
        int iorq_lo;
        int cw_lo;
        int wa_hi;
        int t2_clks;
        int t4_mreq_lo;
        int t4_rd_lo;
    } obs_t;

    localparam logic [6:0] M1 = 7'b0000001;
    localparam logic [6:0] M2 = 7'b0000010;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [6:0] mc, ts;
    logic       intcycle_n, no_read, write, iorq, ext_wait_n;
    logic [7:0] di;

    logic       cw_a, mreq_a, iorq_a, rd_a, wr_a, wa_a;
    logic [7:0] dr_a;
    logic       cw_b, mreq_b, iorq_b, rd_b, wr_b, wa_b;
    logic [7:0] dr_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // A: legacy-like defaults. B: three memory waits and early write.
    tv80_busgen #(.DW(8), .T2WRITE(0), .MEM_WAIT(0), .IO_WAIT(1), .M1_WAIT(0), .RFSH_MREQ(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .mc(mc), .ts(ts), .intcycle_n(intcycle_n),
        .no_read(no_read), .write(write), .iorq(iorq), .ext_wait_n(ext_wait_n),
        .core_wait_n(cw_a), .di(di), .di_reg(dr_a), .mreq_n(mreq_a), .iorq_n(iorq_a),
        .rd_n(rd_a), .wr_n(wr_a), .wait_active(wa_a));

    tv80_busgen #(.DW(8), .T2WRITE(1), .MEM_WAIT(3), .IO_WAIT(1), .M1_WAIT(0), .RFSH_MREQ(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .mc(mc), .ts(ts), .intcycle_n(intcycle_n),
        .no_read(no_read), .write(write), .iorq(iorq), .ext_wait_n(ext_wait_n),
        .core_wait_n(cw_b), .di(di), .di_reg(dr_b), .mreq_n(mreq_b), .iorq_n(iorq_b),
        .rd_n(rd_b), .wr_n(wr_b), .wait_active(wa_b));

    always @(posedge clk) begin
        if (reset_n && !($onehot(ts) && $onehot(mc))) begin
            errors++;
            $display("FAIL onehot: mc=%b ts=%b, required one-hot", mc, ts);
        end
    end

    // Emulated core: T2 repeats while core_wait_n is low; ext_wait_n low for
    // the first ext_lo clocks of T2 and optionally throughout T3.
    task automatic run_cycle(input bit sel, input logic [6:0] m, input int nt,
                             input logic ic_n, input logic nr, input logic wrv, input logic io,
                             input int ext_lo, input bit ext_t3, output obs_t o);
        int t;
        int guard;
        logic s_cw, s_rd, s_wr, s_mreq, s_iorq, s_wa;
        o = '{default: 0};
        t = 0;
        guard = 0;
        while (t < nt && guard < 50) begin
            @(posedge clk); #1;
            mc = m; ts = 7'b1 << t;
            intcycle_n = ic_n; no_read = nr; write = wrv; iorq = io;
            if (t == 1)      ext_wait_n = (o.t2_clks >= ext_lo);
            else if (t == 2) ext_wait_n = !ext_t3;
            else             ext_wait_n = 1'b1;
            @(negedge clk); #1;
            s_cw = sel ? cw_b : cw_a;     s_rd = sel ? rd_b : rd_a;
            s_wr = sel ? wr_b : wr_a;     s_mreq = sel ? mreq_b : mreq_a;
            s_iorq = sel ? iorq_b : iorq_a; s_wa = sel ? wa_b : wa_a;
            if (!s_rd)   o.rd_lo++;
            if (!s_wr)   o.wr_lo++;
            if (!s_mreq) o.mreq_lo++;
            if (!s_iorq) o.iorq_lo++;
            if (s_wa)    o.wa_hi++;
            if (t == 3 && !s_mreq) o.t4_mreq_lo++;
            if (t == 3 && !s_rd)   o.t4_rd_lo++;
            if (t == 1) begin
                o.t2_clks++;
                if (!s_cw) o.cw_lo++;
                else       t = 2;
            end else begin
                t++;
            end
            guard++;
        end
        if (guard >= 50) o.t2_clks = -1;
        $display("cycle sel=%0d mc=%b rd=%0d wr=%0d mreq=%0d iorq=%0d cw=%0d wa=%0d t2=%0d t4mreq=%0d",
                 sel, m, o.rd_lo, o.wr_lo, o.mreq_lo, o.iorq_lo, o.cw_lo, o.wa_hi, o.t2_clks, o.t4_mreq_lo);
    endtask

    task automatic go_idle();
        @(posedge clk); #1;
        mc = M1; ts = 7'b0000001; intcycle_n = 1'b1; no_read = 1'b0;
        write = 1'b0; iorq = 1'b0; ext_wait_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if ({mreq_a, iorq_a, rd_a, wr_a} !== 4'hF) begin errors++; $display("FAIL reset_strobes_a: got %b want 1111", {mreq_a, iorq_a, rd_a, wr_a}); end
        checks++; if ({mreq_b, iorq_b, rd_b, wr_b} !== 4'hF) begin errors++; $display("FAIL reset_strobes_b: got %b want 1111", {mreq_b, iorq_b, rd_b, wr_b}); end
        checks++; if ({wa_a, wa_b} !== 2'b00) begin errors++; $display("FAIL reset_wait_active: got %b want 00", {wa_a, wa_b}); end
        checks++; if (dr_a !== 8'h00 || dr_b !== 8'h00) begin errors++; $display("FAIL reset_di_reg: got %h/%h want 00/00", dr_a, dr_b); end
        checks++; if ({cw_a, cw_b} !== 2'b11) begin errors++; $display("FAIL reset_core_wait: got %b want 11", {cw_a, cw_b}); end
        $display("reset state observed");
    endtask

    task automatic test_legacy();
        obs_t o;
        di = 8'h5A;
        run_cycle(1'b0, M2, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, o);
        checks++; if (o.rd_lo !== 2)   begin errors++; $display("FAIL legacy_rd: got %0d want 2", o.rd_lo); end
        checks++; if (o.mreq_lo !== 2) begin errors++; $display("FAIL legacy_mreq: got %0d want 2", o.mreq_lo); end
        checks++; if (o.iorq_lo !== 0) begin errors++; $display("FAIL legacy_iorq: got %0d want 0", o.iorq_lo); end
        checks++; if (o.t2_clks !== 1) begin errors++; $display("FAIL legacy_t2: got %0d want 1", o.t2_clks); end
        go_idle();
        checks++; if (dr_a !== 8'h5A) begin errors++; $display("FAIL legacy_di_reg: got %h want 5a", dr_a); end
        checks++; if ({mreq_a, rd_a} !== 2'b11) begin errors++; $display("FAIL legacy_release: got %b want 11", {mreq_a, rd_a}); end
        di = 8'h33;
        go_idle();
        checks++; if (dr_a !== 8'h5A) begin errors++; $display("FAIL legacy_di_hold: got %h want 5a", dr_a); end
    endtask

    task automatic test_mem_waits();
        obs_t o;
        di = 8'hC3;
        run_cycle(1'b1, M2, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, o);
        checks++; if (o.cw_lo !== 3)   begin errors++; $display("FAIL memwait_core_wait: got %0d want 3", o.cw_lo); end
        checks++; if (o.wa_hi !== 3)   begin errors++; $display("FAIL memwait_wait_active: got %0d want 3", o.wa_hi); end
        checks++; if (o.rd_lo !== 5)   begin errors++; $display("FAIL memwait_rd: got %0d want 5", o.rd_lo); end
        checks++; if (o.t2_clks !== 4) begin errors++; $display("FAIL memwait_t2: got %0d want 4", o.t2_clks); end
        go_idle();
        checks++; if (dr_b !== 8'hC3) begin errors++; $display("FAIL memwait_di_reg: got %h want c3", dr_b); end
    endtask

    task automatic test_io_ext_wait();
        obs_t o;
        run_cycle(1'b0, M2, 3, 1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b0, o);
        checks++; if (o.t2_clks !== 5) begin errors++; $display("FAIL io_t2: got %0d want 5", o.t2_clks); end
        checks++; if (o.cw_lo !== 4)   begin errors++; $display("FAIL io_core_wait: got %0d want 4", o.cw_lo); end
        checks++; if (o.wa_hi !== 1)   begin errors++; $display("FAIL io_wait_active: got %0d want 1", o.wa_hi); end
        checks++; if (o.wr_lo !== 1 || o.iorq_lo !== 1) begin errors++; $display("FAIL io_wr_iorq: got wr=%0d iorq=%0d want 1/1", o.wr_lo, o.iorq_lo); end
        checks++; if (o.mreq_lo !== 0 || o.rd_lo !== 0) begin errors++; $display("FAIL io_mreq_rd: got mreq=%0d rd=%0d want 0/0", o.mreq_lo, o.rd_lo); end
        go_idle();
    endtask

    task automatic test_t2write();
        obs_t o;
        run_cycle(1'b1, M2, 3, 1'b1, 1'b0, 1'b1, 1'b0, 0, 1'b1, o);
        checks++; if (o.wr_lo !== 5)   begin errors++; $display("FAIL t2w_wr: got %0d want 5", o.wr_lo); end
        checks++; if (o.mreq_lo !== 5) begin errors++; $display("FAIL t2w_mreq: got %0d want 5", o.mreq_lo); end
        checks++; if (o.rd_lo !== 0 || o.iorq_lo !== 0) begin errors++; $display("FAIL t2w_rd_iorq: got rd=%0d iorq=%0d want 0/0", o.rd_lo, o.iorq_lo); end
        checks++; if (o.t2_clks !== 4) begin errors++; $display("FAIL t2w_t2: got %0d want 4", o.t2_clks); end
        go_idle();
        checks++; if (wr_b !== 1'b1) begin errors++; $display("FAIL t2w_release: got %b want 1", wr_b); end
    endtask

    task automatic test_inta_refresh();
        obs_t o;
        run_cycle(1'b0, M1, 4, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, o);
        checks++; if (o.iorq_lo !== 3) begin errors++; $display("FAIL inta_iorq: got %0d want 3", o.iorq_lo); end
        checks++; if (o.rd_lo !== 0 || o.mreq_lo !== 0) begin errors++; $display("FAIL inta_rd_mreq: got rd=%0d mreq=%0d want 0/0", o.rd_lo, o.mreq_lo); end
        checks++; if (o.t2_clks !== 2) begin errors++; $display("FAIL inta_t2: got %0d want 2", o.t2_clks); end
        run_cycle(1'b0, M1, 4, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, o);
        checks++; if (o.t4_mreq_lo !== 1 || o.t4_rd_lo !== 0) begin errors++; $display("FAIL rfsh_t4: got mreq=%0d rd=%0d want 1/0", o.t4_mreq_lo, o.t4_rd_lo); end
        checks++; if (o.rd_lo !== 2 || o.mreq_lo !== 3) begin errors++; $display("FAIL fetch_rd_mreq: got rd=%0d mreq=%0d want 2/3", o.rd_lo, o.mreq_lo); end
        checks++; if (o.iorq_lo !== 0) begin errors++; $display("FAIL fetch_iorq: got %0d want 0", o.iorq_lo); end
        go_idle();
    endtask

    task automatic test_abort();
        @(posedge clk); #1;
        mc = M2; ts = 7'b0000001; no_read = 1'b0; write = 1'b0; iorq = 1'b0;
        @(posedge clk); #1; ts = 7'b0000010;
        @(posedge clk); #1; ts = 7'b0000001; no_read = 1'b1;
        @(negedge clk); #1;
        checks++; if (wa_b !== 1'b1) begin errors++; $display("FAIL abort_pending: got %b want 1", wa_b); end
        @(posedge clk); #1; ts = 7'b0000010;
        @(negedge clk); #1;
        checks++; if (wa_b !== 1'b0 || cw_b !== 1'b1) begin errors++; $display("FAIL abort_reload: got wa=%b cw=%b want 0/1", wa_b, cw_b); end
        $display("abort transaction done");
        go_idle();
    endtask

    task automatic test_reset_mid();
        obs_t o;
        @(posedge clk); #1;
        mc = M2; ts = 7'b0000001; no_read = 1'b0; write = 1'b0; iorq = 1'b0;
        @(posedge clk); #1; ts = 7'b0000010;
        @(negedge clk); #1;
        checks++; if (rd_b !== 1'b0 || wa_b !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got rd=%b wa=%b want 0/1", rd_b, wa_b); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({mreq_b, iorq_b, rd_b, wr_b} !== 4'hF) begin errors++; $display("FAIL rstmid_strobes: got %b want 1111", {mreq_b, iorq_b, rd_b, wr_b}); end
        checks++; if (wa_b !== 1'b0) begin errors++; $display("FAIL rstmid_wait_active: got %b want 0", wa_b); end
        checks++; if (dr_b !== 8'h00) begin errors++; $display("FAIL rstmid_di_reg: got %h want 00", dr_b); end
        mc = M1; ts = 7'b0000001;
        @(negedge clk); #1;
        reset_n = 1'b1;
        di = 8'h96;
        run_cycle(1'b1, M2, 3, 1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0, o);
        checks++; if (o.rd_lo !== 5 || o.t2_clks !== 4) begin errors++; $display("FAIL rstmid_recover: got rd=%0d t2=%0d want 5/4", o.rd_lo, o.t2_clks); end
        go_idle();
        checks++; if (dr_b !== 8'h96) begin errors++; $display("FAIL rstmid_recover_di: got %h want 96", dr_b); end
    endtask

    initial begin
        reset_n = 1'b0;
        mc = M1; ts = 7'b0000001; intcycle_n = 1'b1; no_read = 1'b0;
        write = 1'b0; iorq = 1'b0; ext_wait_n = 1'b1; di = 8'h00;
        #12;
        test_reset();
        @(negedge clk); #1;
        reset_n = 1'b1;
        go_idle();
        test_legacy();
        test_mem_waits();
        test_io_ext_wait();
        test_t2write();
        test_inta_refresh();
        test_abort();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
